// File: rtl/pulse_shaper.sv
// Minimum-hold pulse shaper: follows i_level but keeps every new o_out level
// for at least p_MIN_HIGH / p_MIN_LOW cycles, absorbing shorter request pulses.
module pulse_shaper #(
    parameter int p_MIN_HIGH = 5,
    parameter int p_MIN_LOW  = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_level,
    output logic        o_out,
    output logic        o_edge,
    output logic        o_busy,
    output logic        o_pending,
    output logic [15:0] o_toggles
);
    localparam int MAX_HOLD = (p_MIN_HIGH > p_MIN_LOW) ? p_MIN_HIGH : p_MIN_LOW;
    localparam int CW       = $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] MIN_HIGH = CW'(p_MIN_HIGH);
    localparam logic [CW-1:0] MIN_LOW  = CW'(p_MIN_LOW);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        HOLD_LOW  = 2'd1,
        HOLD_HIGH = 2'd2,
        IDLE_HIGH = 2'd3
    } state_t;

    state_t        state_q   = IDLE_LOW;
    state_t        state_d;
    logic [CW-1:0] cnt_q     = '0;
    logic [CW-1:0] cnt_d;
    logic          edge_q    = 1'b0;
    logic          edge_d;
    logic [15:0]   toggles_q = '0;

    // Only the level seen on the expiring cycle matters; earlier requests are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (i_level) begin
                    state_d = HOLD_HIGH;
                    cnt_d   = ONE;
                    edge_d  = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!i_level) begin
                    state_d = HOLD_LOW;
                    cnt_d   = ONE;
                    edge_d  = 1'b1;
                end
            end
            HOLD_HIGH: begin
                if (cnt_q < MIN_HIGH) begin
                    cnt_d = cnt_q + ONE;
                end else if (!i_level) begin
                    state_d = HOLD_LOW;
                    cnt_d   = ONE;
                    edge_d  = 1'b1;
                end else begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end
            end
            HOLD_LOW: begin
                if (cnt_q < MIN_LOW) begin
                    cnt_d = cnt_q + ONE;
                end else if (i_level) begin
                    state_d = HOLD_HIGH;
                    cnt_d   = ONE;
                    edge_d  = 1'b1;
                end else begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            edge_q    <= 1'b0;
            toggles_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            if (edge_d) toggles_q <= toggles_q + 16'd1;
        end
    end

    assign o_out     = (state_q == HOLD_HIGH) || (state_q == IDLE_HIGH);
    assign o_busy    = (state_q == HOLD_HIGH) || (state_q == HOLD_LOW);
    assign o_edge    = edge_q;
    assign o_pending = o_busy && (i_level != o_out);
    assign o_toggles = toggles_q;

endmodule

// File: tb/tb_pulse_shaper.sv
// Random + directed bench for pulse_shaper against an age-based level model.
module tb_pulse_shaper;
    localparam int MH = 5;
    localparam int ML = 3;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b1;
    logic        i_level = 1'b0;
    logic        o_out, o_edge, o_busy, o_pending;
    logic [15:0] o_toggles;

    pulse_shaper #(.p_MIN_HIGH(MH), .p_MIN_LOW(ML)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_level   (i_level),
        .o_out     (o_out),
        .o_edge    (o_edge),
        .o_busy    (o_busy),
        .o_pending (o_pending),
        .o_toggles (o_toggles)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: output level plus cycles since it last changed (1000 = long ago / after reset).
    logic        m_out = 1'b0;
    int          m_age = 1000;
    logic [15:0] m_tog = '0;
    bit          m_rst_edge = 1'b1;

    function automatic int min_of(input logic lvl);
        return lvl ? MH : ML;
    endfunction

    always @(posedge i_clk) begin
        m_rst_edge = i_rst;
        if (i_rst) begin
            m_out = 1'b0;
            m_age = 1000;
            m_tog = '0;
        end else if (i_level != m_out && m_age >= min_of(m_out)) begin
            m_out = i_level;
            m_age = 1;
            m_tog = m_tog + 16'd1;
        end else if (m_age < 1000) begin
            m_age++;
        end
    end

    // Per-cycle compare plus interval-length and edge-count monitors.
    logic prev_out = 1'b0;
    int   run_len  = 0;
    bit   low_from_transition = 1'b0;
    int   edge_cnt = 0;

    always @(negedge i_clk) begin
        logic m_busy;
        m_busy = (m_age <= min_of(m_out));
        chk("out",     o_out,     m_out);
        chk("edge",    o_edge,    m_age == 1);
        chk("busy",    o_busy,    m_busy);
        chk("pending", o_pending, m_busy && (i_level != m_out));
        chk("toggles", o_toggles, m_tog);
        if (o_edge) edge_cnt++;
        if (m_rst_edge) begin
            run_len = 1;
            low_from_transition = 1'b0;
        end else if (o_out != prev_out) begin
            if (prev_out)                 chk("high_interval_ge_min", run_len >= MH, 1);
            else if (low_from_transition) chk("low_interval_ge_min",  run_len >= ML, 1);
            low_from_transition = !o_out;
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_out = o_out;
    end

    // Apply a level, take one edge, return 1 time unit after it.
    task automatic cyc(input logic lvl);
        i_level = lvl;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        i_rst = 1'b0;
    endtask

    initial begin
        int          n;
        int          e0;
        logic [15:0] t0;
        logic        lvl;

        do_reset();
        chk("rst_out", o_out, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_toggles", o_toggles, 0);

        // Level held high from idle: 1-cycle latency, 5 busy cycles.
        cyc(1'b1);
        chk("rise_out", o_out, 1);
        chk("rise_edge", o_edge, 1);
        chk("rise_busy", o_busy, 1);
        chk("rise_toggles", o_toggles, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        chk("hold5_busy", o_busy, 1);
        chk("hold5_edge", o_edge, 0);
        cyc(1'b1);
        chk("idle_high_busy", o_busy, 0);
        chk("idle_high_out", o_out, 1);

        // Single-cycle pulse stretched to 5 high then 3 low.
        do_reset();
        n = 0;
        cyc(1'b1);
        for (int i = 0; i < 10; i++) begin
            n += int'(o_out);
            cyc(1'b0);
        end
        chk("pulse_high_cycles", n, 5);
        chk("pulse_end_out", o_out, 0);
        chk("pulse_end_busy", o_busy, 0);
        chk("pulse_toggles", o_toggles, 2);

        // Toggle every cycle: absorbed requests, alternation 5/3.
        lvl = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(lvl);
            lvl = ~lvl;
        end

        // Reset in the 3rd cycle of a high hold, then immediate re-rise.
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("mid_hold_busy", o_busy, 1);
        i_rst = 1'b1;
        cyc(1'b1);
        chk("mid_rst_out", o_out, 0);
        chk("mid_rst_toggles", o_toggles, 0);
        i_rst = 1'b0;
        cyc(1'b1);
        chk("post_rst_out", o_out, 1);
        chk("post_rst_toggles", o_toggles, 1);

        // Counter wrap from 0xFFFF.
        do_reset();
        cyc(1'b0);
        force dut.toggles_q = 16'hFFFF;
        #1;
        release dut.toggles_q;
        m_tog = 16'hFFFF;
        cyc(1'b1);
        chk("wrap_toggles", o_toggles, 0);
        for (int i = 0; i < MH + 1; i++) cyc(1'b1);

        // Random run.
        t0 = o_toggles;
        e0 = edge_cnt;
        lvl = i_level;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) lvl = ~lvl;
            cyc(lvl);
        end
        @(negedge i_clk);
        chk("edge_count_vs_toggles", 32'(edge_cnt - e0), 32'(o_toggles - t0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_shaper.md
PULSE_SHAPER -- requirements
Module: pulse_shaper

Interface
REQ-001 The block SHALL provide parameter p_MIN_HIGH, default 5: minimum number of consecutive cycles o_out is held at 1, legal range 1..255.
REQ-002 The block SHALL provide parameter p_MIN_LOW, default 5: minimum number of consecutive cycles o_out is held at 0, legal range 1..255.
REQ-003 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_level  input  1  requested output level, sampled every rising edge.
REQ-006 o_out  output  1  shaped output level, registered.
REQ-007 o_edge  output  1  one-cycle strobe, high in the first cycle of every new o_out level, registered.
REQ-008 o_busy  output  1  high while a minimum-hold interval is still running.
REQ-009 o_pending  output  1  high when o_busy is high and i_level differs from o_out (combinational).
REQ-010 o_toggles  output  16  count of o_out transitions since reset, registered.

Function
REQ-011 The block SHALL implement the states IDLE_LOW, HOLD_LOW, HOLD_HIGH and IDLE_HIGH. o_out is 0 in the *_LOW states and 1 in the *_HIGH states.
REQ-012 The block SHALL contain a hold counter of width $clog2(max(p_MIN_HIGH,p_MIN_LOW)+1). The counter is 1 in the first cycle of a hold state and increments by 1 each cycle while the hold state is unfinished.
REQ-013 IDLE_LOW: i_level=1 -> HOLD_HIGH with counter=1; otherwise the state is unchanged.
REQ-014 IDLE_HIGH: i_level=0 -> HOLD_LOW with counter=1; otherwise the state is unchanged.
REQ-015 HOLD_HIGH with counter<p_MIN_HIGH: counter increments and the state is unchanged, regardless of i_level.
REQ-016 HOLD_HIGH with counter==p_MIN_HIGH: i_level=0 -> HOLD_LOW with counter=1; i_level=1 -> IDLE_HIGH.
REQ-017 HOLD_LOW with counter<p_MIN_LOW: counter increments and the state is unchanged, regardless of i_level.
REQ-018 HOLD_LOW with counter==p_MIN_LOW: i_level=1 -> HOLD_HIGH with counter=1; i_level=0 -> IDLE_LOW.
REQ-019 Latency from idle SHALL be 1 cycle: i_level sampled at edge N differing from o_out makes o_out change after edge N.
REQ-020 A request arriving during a hold SHALL NOT be queued as an event. Only the i_level value sampled at the edge where the hold expires decides the next state; pulses on i_level shorter than the remaining hold are absorbed.
REQ-021 Each o_out high interval SHALL be >= p_MIN_HIGH cycles. Each low interval after the first transition SHALL be >= p_MIN_LOW cycles.
REQ-022 o_edge SHALL be 1 exactly in the cycles where the state has just entered HOLD_HIGH or HOLD_LOW; otherwise it is 0.
REQ-023 o_busy SHALL be 1 in HOLD_HIGH and HOLD_LOW, and 0 in the IDLE states.
REQ-024 o_toggles SHALL increment by 1 on each entry into HOLD_HIGH or HOLD_LOW, and wrap from 0xFFFF to 0x0000 with no saturation.
REQ-025 An unreachable state encoding SHALL return to IDLE_LOW on the next edge with counter=0.

Reset
REQ-026 i_rst=1 at an edge SHALL force state=IDLE_LOW, counter=0, o_out=0, o_edge=0, o_toggles=0, regardless of i_level or the current state. Consequently o_busy=0 and o_pending=0.
REQ-027 Reset asserted mid-hold SHALL abandon the hold immediately, with no minimum-time guarantee across reset.
REQ-028 The first edge with i_rst=0 SHALL be evaluated as IDLE_LOW: i_level=1 there produces o_out=1 after that edge.
REQ-029 Power-up register values SHALL equal the reset values.

Verification
REQ-030 Settings p_MIN_HIGH=5, p_MIN_LOW=3; reset, i_level=1 held -> o_out rises 1 cycle later, o_edge=1 for 1 cycle, o_busy=1 for 5 cycles then 0, o_toggles=1.
REQ-031 Settings p_MIN_HIGH=5; from IDLE_LOW apply a 1-cycle i_level=1 pulse -> o_out high for exactly 5 cycles, then HOLD_LOW for 3 cycles, then IDLE_LOW; o_toggles=2.
REQ-032 i_level toggles every cycle for 40 cycles -> o_out alternates with high intervals of exactly 5 cycles and low intervals of exactly 3 cycles; o_pending is high whenever i_level != o_out during a hold.
REQ-033 Assert i_rst in the 3rd cycle of HOLD_HIGH with i_level=1 -> o_out=0, o_toggles=0 after the edge; on the next edge with i_rst=0, o_out=1 again.
REQ-034 Force o_toggles to 0xFFFF (preload via 65535 transitions, or force) and produce one transition -> o_toggles=0x0000.
REQ-035 Random i_level run of 10k cycles -> a checker confirms REQ-021, and confirms o_edge count equals o_toggles delta.
